// File: rtl/fft_butterfly6_pkg.sv
// fft_butterfly6_pkg: shared widths, limits and complex-pair type for the stage-6 butterfly
package fft_butterfly6_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int W_W_DEF = 16;
  localparam int W_FRAC_DEF = 14;
  localparam int W_ONE = 1 << W_FRAC_DEF;
  localparam int DATA_MAX = (1 << (DATA_W_DEF - 1)) - 1;
  localparam int DATA_MIN = -(1 << (DATA_W_DEF - 1));
  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] re;
    logic signed [DATA_W_DEF-1:0] im;
  } cplx_t;
endpackage

// File: rtl/fft_butterfly6_cmplx_mult_pipe.sv
// cmplx_mult_pipe: two-stage registered complex multiply b*W with round-half-up to DATA_W+2 bits
module cmplx_mult_pipe
  import fft_butterfly6_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int W_W = W_W_DEF,
  parameter int W_FRAC = W_FRAC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a_real,
  input  logic [DATA_W-1:0] a_imag,
  input  logic [DATA_W-1:0] b_real,
  input  logic [DATA_W-1:0] b_imag,
  input  logic [W_W-1:0]    w_real,
  input  logic [W_W-1:0]    w_imag,
  output logic              valid,
  output logic [DATA_W-1:0] s2_a_real,
  output logic [DATA_W-1:0] s2_a_imag,
  output logic [DATA_W+1:0] p_real,
  output logic [DATA_W+1:0] p_imag
);
  localparam int PW = DATA_W + W_W;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] HALF = SW'(1) <<< (W_FRAC - 1);
  logic v1;
  logic signed [DATA_W-1:0] a1_r, a1_i, b1_r, b1_i;
  logic signed [W_W-1:0] w1_r, w1_i;
  logic signed [PW-1:0] rr, ii, ri, ir;
  logic signed [SW-1:0] pr, pi;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      valid <= 1'b0;
      {a1_r, a1_i, b1_r, b1_i, w1_r, w1_i} <= '0;
      {s2_a_real, s2_a_imag, rr, ii, ri, ir} <= '0;
    end else begin
      v1 <= in_valid;
      valid <= v1;
      if (in_valid) begin
        a1_r <= a_real;
        a1_i <= a_imag;
        b1_r <= b_real;
        b1_i <= b_imag;
        w1_r <= w_real;
        w1_i <= w_imag;
      end
      if (v1) begin
        s2_a_real <= a1_r;
        s2_a_imag <= a1_i;
        rr <= PW'(b1_r) * PW'(w1_r);
        ii <= PW'(b1_i) * PW'(w1_i);
        ri <= PW'(b1_r) * PW'(w1_i);
        ir <= PW'(b1_i) * PW'(w1_r);
      end
    end
  end
  assign pr = SW'(rr) - SW'(ii) + HALF;
  assign pi = SW'(ri) + SW'(ir) + HALF;
  // arithmetic shift floors, so the pre-added half gives round-half-up
  assign p_real = (DATA_W + 2)'(pr >>> W_FRAC);
  assign p_imag = (DATA_W + 2)'(pi >>> W_FRAC);
endmodule

// File: rtl/fft_butterfly6.sv
// fft_butterfly6: radix-2 DIT butterfly X0=a+Wb, X1=a-Wb with scaling, saturation and sticky overflow
module fft_butterfly6
  import fft_butterfly6_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int W_W = W_W_DEF,
  parameter int W_FRAC = W_FRAC_DEF,
  parameter int SCALE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a_real,
  input  logic [DATA_W-1:0] a_imag,
  input  logic [DATA_W-1:0] b_real,
  input  logic [DATA_W-1:0] b_imag,
  input  logic [W_W-1:0]    W_real,
  input  logic [W_W-1:0]    W_imag,
  input  logic              ovf_clr,
  output logic              out_valid,
  output logic [DATA_W-1:0] x0_real,
  output logic [DATA_W-1:0] x0_imag,
  output logic [DATA_W-1:0] x1_real,
  output logic [DATA_W-1:0] x1_imag,
  output logic              ovf
);
  localparam int AW = DATA_W + 3;
  localparam logic signed [AW-1:0] MAXV = AW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = AW'(-(2 ** (DATA_W - 1)));
  logic v2;
  logic signed [DATA_W-1:0] ar, ai;
  logic signed [DATA_W+1:0] pr, pi;
  logic [DATA_W-1:0] c [4];
  logic [3:0] sat;
  cmplx_mult_pipe #(
    .DATA_W(DATA_W),
    .W_W(W_W),
    .W_FRAC(W_FRAC)
  ) u_mult (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .a_real(a_real),
    .a_imag(a_imag),
    .b_real(b_real),
    .b_imag(b_imag),
    .w_real(W_real),
    .w_imag(W_imag),
    .valid(v2),
    .s2_a_real(ar),
    .s2_a_imag(ai),
    .p_real(pr),
    .p_imag(pi)
  );
  // lanes 0/1 are x0 real/imag, lanes 2/3 are x1 real/imag
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic signed [AW-1:0] a_ext, p_ext, sum, scl;
    assign a_ext = AW'(i % 2 == 0 ? ar : ai);
    assign p_ext = AW'(i % 2 == 0 ? pr : pi);
    assign sum = i < 2 ? a_ext + p_ext : a_ext - p_ext;
    assign scl = SCALE != 0 ? (sum + AW'(1)) >>> 1 : sum;
    assign sat[i] = scl > MAXV || scl < MINV;
    assign c[i] = scl > MAXV ? MAXV[DATA_W-1:0] : scl < MINV ? MINV[DATA_W-1:0] : scl[DATA_W-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      {x0_real, x0_imag, x1_real, x1_imag} <= '0;
      ovf <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        x0_real <= c[0];
        x0_imag <= c[1];
        x1_real <= c[2];
        x1_imag <= c[3];
      end
      if (ovf_clr) ovf <= 1'b0;
      if (v2 && |sat) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fft_butterfly6.sv
// tb_fft_butterfly6: scoreboard bench for unscaled and scaled butterflies against an integer reference model
module tb_fft_butterfly6;
  typedef struct packed {
    logic [3:0][31:0] x;
    logic sat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic ovf_clr = 1'b0;
  logic [15:0] a_real = '0, a_imag = '0, b_real = '0, b_imag = '0, W_real = '0, W_imag = '0;
  logic ov [2];
  logic oo [2];
  logic [15:0] ox [2][4];
  logic [2:0] hist;
  logic clr_q;
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t last [2];
  bit eo [2];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fft_butterfly6 u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .W_real(W_real), .W_imag(W_imag), .ovf_clr(ovf_clr),
    .out_valid(ov[0]), .x0_real(ox[0][0]), .x0_imag(ox[0][1]),
    .x1_real(ox[0][2]), .x1_imag(ox[0][3]), .ovf(oo[0])
  );
  fft_butterfly6 #(.SCALE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .W_real(W_real), .W_imag(W_imag), .ovf_clr(ovf_clr),
    .out_valid(ov[1]), .x0_real(ox[1][0]), .x0_imag(ox[1][1]),
    .x1_real(ox[1][2]), .x1_imag(ox[1][3]), .ovf(oo[1])
  );
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  function automatic longint wrap18(input longint v);
    longint m;
    m = v & 64'h3FFFF;
    return m >= 131072 ? m - 262144 : m;
  endfunction
  function automatic exp_t model(input int ar, ai, br, bi, wr, wi, input bit scale);
    exp_t e;
    longint pr, pi, s;
    longint p [2];
    int a [2];
    pr = longint'(br) * wr - longint'(bi) * wi;
    pi = longint'(br) * wi + longint'(bi) * wr;
    p[0] = wrap18((pr + 8192) >>> 14);
    p[1] = wrap18((pi + 8192) >>> 14);
    a[0] = ar;
    a[1] = ai;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      s = k < 2 ? a[k % 2] + p[k % 2] : a[k % 2] - p[k % 2];
      if (scale) s = (s + 1) >>> 1;
      if (s > 32767) begin s = 32767; e.sat = 1'b1; end
      else if (s < -32768) begin s = -32768; e.sat = 1'b1; end
      e.x[k] = 32'(s);
    end
    return e;
  endfunction
  function automatic int rs16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction
  function automatic int rw();
    return int'($urandom_range(0, 32768)) - 16384;
  endfunction
  task automatic drive(input bit v, input int ar, ai, br, bi, wr, wi, input bit clr);
    @(negedge clk);
    #1;
    in_valid = v;
    a_real = 16'(ar);
    a_imag = 16'(ai);
    b_real = 16'(br);
    b_imag = 16'(bi);
    W_real = 16'(wr);
    W_imag = 16'(wi);
    ovf_clr = clr;
    if (v) begin
      q0.push_back(model(ar, ai, br, bi, wr, wi, 1'b0));
      q1.push_back(model(ar, ai, br, bi, wr, wi, 1'b1));
    end
  endtask
  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(1'b0, rs16(), rs16(), rs16(), rs16(), rw(), rw(), 1'b0);
  endtask
  task automatic stream(input int n);
    for (int j = 0; j < n; j++)
      drive(j % 4 != 2, rs16(), rs16(), rs16(), rs16(), rw(), rw(), $urandom_range(0, 15) == 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    ovf_clr = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_valid%0d", d), int'(ov[d]), 0);
      chk($sformatf("rst_ovf%0d", d), int'(oo[d]), 0);
      for (int k = 0; k < 4; k++) chk($sformatf("rst_d%0d_x%0d", d, k), int'($signed(ox[d][k])), 0);
    end
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask
  always @(posedge clk or posedge rst)
    if (rst) hist <= '0;
    else hist <= {hist[1:0], in_valid};
  always @(posedge clk) clr_q <= ovf_clr;
  always @(negedge clk) begin
    bit sat_now;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        eo[d] = 1'b0;
        last[d] = '0;
      end else begin
        chk($sformatf("valid%0d", d), int'(ov[d]), int'(hist[2]));
        sat_now = 1'b0;
        if (ov[d]) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) chk($sformatf("underflow%0d", d), 1, 0);
          else begin
            last[d] = d == 0 ? q0.pop_front() : q1.pop_front();
            sat_now = last[d].sat;
          end
        end
        for (int k = 0; k < 4; k++)
          chk($sformatf("d%0d_x%0d", d, k), int'($signed(ox[d][k])), int'(last[d].x[k]));
        eo[d] = (eo[d] && !clr_q) || sat_now;
        chk($sformatf("ovf%0d", d), int'(oo[d]), int'(eo[d]));
      end
    end
  end
  initial begin
    do_reset();
    drive(1'b1, 100, 50, 20, -10, 16384, 0, 1'b0);
    drive(1'b1, 100, 50, 20, -10, 0, -16384, 1'b0);
    idle(3);
    drive(1'b1, 0, 0, 1, 0, 8192, 0, 1'b0);
    drive(1'b1, 0, 0, -1, 0, 8192, 0, 1'b0);
    idle(4);
    drive(1'b1, 32767, 0, 32767, 0, 16384, 0, 1'b0);
    idle(5);
    drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
    idle(3);
    drive(1'b1, 32767, 0, 32767, 0, 16384, 0, 1'b0);
    idle(1);
    drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
    idle(4);
    drive(1'b1, -32768, -32768, 32767, 32767, 16384, 0, 1'b0);
    idle(4);
    stream(171);
    idle(4);
    stream(21);
    do_reset();
    idle(2);
    stream(16);
    idle(6);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
